round_sequencer: RTL and testbench
==================================

// Module: round_sequencer
// PURPOSE
//  Multi-round controller for the reaction game. Sequences the counter datapath through
//  ARM -> RUN -> JUDGE -> SHOW, and latches a random target per round. Computes the
//  per-round error |number - target|, accumulates a saturating total, and drives the
//  per-round hit LEDs. Sits between the button/mode front end and the counter/display path.
// PARAMETERS
//  ROUNDS      4          rounds per game, 1..16; selects led[ROUNDS-1:0]
//  WIN_THRESH  500        round is a hit when err < WIN_THRESH
//  MAX_NUM     9999       RUN times out when number >= MAX_NUM
//  SHOW_TICKS  100000000  clk cycles SHOW is held before the next round (1 s @ 100 MHz)
// PORTS
//  clk         in   1   system clock; single clock domain
//  rst         in   1   synchronous, active-high reset
//  btnS        in   1   start/stop button, already synchronised, level
//  rand        in   14  free-running random source
//  number      in   14  counter datapath value
//  count_en    out  1   datapath increments while high
//  count_clr   out  1   one-cycle pulse: datapath clears number to 0
//  select      out  2   phase to display: 0 IDLE, 3 ARM, 1 RUN, 2 JUDGE/SHOW/DONE
//  target      out  14  latched target for the current round
//  err         out  14  error of the last judged round
//  total       out  16  saturating sum of round errors
//  round_idx   out  4   current round, 0-based
//  led         out  16  led[r] = 1 when round r was a hit
//  done        out  1   high in DONE
// BEHAVIOUR
//  - All outputs are registered. Reset (rst high at a clk edge) forces:
//    state=IDLE, select=0, count_en=0, count_clr=0, target=0, err=0, total=0,
//    round_idx=0, led=0, done=0, and timers=0.
//  - press = btnS & ~btnS_q. btnS_q resets to 1, so a button held through reset
//    gives no press until it is released and pressed again.
//  - IDLE: on press -> ARM; total, led and round_idx are cleared; count_clr pulses.
//  - ARM: target <= (rand > MAX_NUM-1) ? rand - MAX_NUM : rand.
//    target is sampled on the first ARM cycle only. Wait for the next press -> RUN.
//    count_clr pulses on entry to RUN.
//  - RUN: count_en=1.
//    - press -> JUDGE.
//    - number >= MAX_NUM -> JUDGE (timeout).
//    - If both occur in the same cycle, the result is one JUDGE (no double step).
//    - count_en drops in the cycle JUDGE is entered.
//  - JUDGE (exactly 1 cycle):
//    - err <= |number - target|, using the number value sampled on the JUDGE cycle.
//    - total <= min(total + err, 16'hFFFF).
//    - led[round_idx] <= (err < WIN_THRESH).
//    - -> SHOW with timer=0.
//  - SHOW: timer counts up to SHOW_TICKS-1; press is ignored.
//    - If round_idx == ROUNDS-1 -> DONE.
//    - Else round_idx++ and -> ARM.
//  - DONE: done=1; all results are held. A press -> IDLE; done is cleared on that
//    transition.
//  - Mid-operation reset: rst wins over every transition and takes effect in the
//    same cycle; no partial score is kept.
//  - Arithmetic: err uses 15-bit signed subtraction, then magnitude; total uses a
//    17-bit sum, then saturation.
//  - led[15:ROUNDS] stay 0.
// TESTING
//  1. Reset: drive rst for 2 cycles with btnS=1 -> all outputs 0, state IDLE; holding
//     btnS after reset gives no transition.
//  2. Single round, ROUNDS=1, rand=1200, stop with number=1300 -> target=1200, err=100,
//     led[0]=1, total=100, done=1 after SHOW_TICKS.
//  3. Timeout: target=50, never press in RUN -> JUDGE when number=9999, err=9949,
//     led[0]=0, count_en=0 the next cycle.
//  4. Saturation: 8 rounds of timeout with target=0 -> total=16'hFFFF, not a wrap to 14456.
//  5. Press and timeout in the same cycle -> exactly one JUDGE; round_idx advances
//     by 1 only.
//  6. rst asserted during RUN with number=4000 -> next cycle IDLE, count_en=0,
//     total=0, led=0.
//  Run with SHOW_TICKS=8 for simulation.

Source files
------------

// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - multi-round reaction game controller: phase sequencing, target latch, error scoring
module round_sequencer #(
    parameter int ROUNDS     = 4,
    parameter int WIN_THRESH = 500,
    parameter int MAX_NUM    = 9999,
    parameter int SHOW_TICKS = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btnS,
    input  logic [13:0] rand_num,
    input  logic [13:0] number,
    output logic        count_en,
    output logic        count_clr,
    output logic [1:0]  select,
    output logic [13:0] target,
    output logic [13:0] err,
    output logic [15:0] total,
    output logic [3:0]  round_idx,
    output logic [15:0] led,
    output logic        done
);

    localparam logic [13:0] MAX_N     = 14'(MAX_NUM);
    localparam logic [13:0] WIN_T     = 14'(WIN_THRESH);
    localparam logic [3:0]  LAST_R    = 4'(ROUNDS - 1);
    localparam logic [31:0] SHOW_LAST = 32'(SHOW_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_JUDGE,
        S_SHOW,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic        btns_q;
    logic        press;
    logic        arm_new;
    logic [31:0] timer;

    logic signed [14:0] diff;
    logic signed [14:0] diff_mag;
    logic        [13:0] err_calc;
    logic        [16:0] sum_calc;
    logic        [1:0]  select_nxt;

    // Rising edge of the (already synchronised) start/stop button.
    assign press = btnS & ~btns_q;

    // Round error magnitude and 17-bit running sum used in the judge cycle.
    always_comb begin
        diff     = $signed({1'b0, number}) - $signed({1'b0, target});
        diff_mag = diff[14] ? -diff : diff;
        err_calc = diff_mag[13:0];
        sum_calc = {1'b0, total} + {3'b000, err_calc};
    end

    // Next-state logic and the display phase code of the upcoming state.
    always_comb begin
        state_nxt  = state;
        select_nxt = 2'd0;
        case (state)
            S_IDLE:  if (press) state_nxt = S_ARM;
            S_ARM:   if (press) state_nxt = S_RUN;
            S_RUN:   if (press || (number >= MAX_N)) state_nxt = S_JUDGE;
            S_JUDGE: state_nxt = S_SHOW;
            S_SHOW: begin
                if (timer == SHOW_LAST) begin
                    state_nxt = (round_idx == LAST_R) ? S_DONE : S_ARM;
                end
            end
            S_DONE:  if (press) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        case (state_nxt)
            S_IDLE:  select_nxt = 2'd0;
            S_ARM:   select_nxt = 2'd3;
            S_RUN:   select_nxt = 2'd1;
            default: select_nxt = 2'd2;
        endcase
    end

    // State register and button history; held button through reset gives no press.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            btns_q <= 1'b1;
        end else begin
            state  <= state_nxt;
            btns_q <= btnS;
        end
    end

    // Registered outputs, show timer and per-round scoring.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_en  <= 1'b0;
            count_clr <= 1'b0;
            select    <= 2'd0;
            target    <= 14'd0;
            err       <= 14'd0;
            total     <= 16'd0;
            round_idx <= 4'd0;
            led       <= 16'd0;
            done      <= 1'b0;
            timer     <= 32'd0;
            arm_new   <= 1'b0;
        end else begin
            count_en  <= (state_nxt == S_RUN);
            count_clr <= ((state == S_IDLE) && (state_nxt == S_ARM)) ||
                         ((state == S_ARM)  && (state_nxt == S_RUN));
            select    <= select_nxt;
            done      <= (state_nxt == S_DONE);
            arm_new   <= (state_nxt == S_ARM) && (state != S_ARM);

            // A new game starts with a clean score.
            if ((state == S_IDLE) && (state_nxt == S_ARM)) begin
                total     <= 16'd0;
                led       <= 16'd0;
                round_idx <= 4'd0;
            end

            // Target is folded into 0..MAX_NUM-1 and taken once per round.
            if ((state == S_ARM) && arm_new) begin
                target <= (rand_num >= MAX_N) ? (rand_num - MAX_N) : rand_num;
            end

            if (state == S_JUDGE) begin
                err            <= err_calc;
                total          <= sum_calc[16] ? 16'hFFFF : sum_calc[15:0];
                led[round_idx] <= (err_calc < WIN_T);
            end

            if (state == S_SHOW) begin
                timer <= timer + 32'd1;
            end else begin
                timer <= 32'd0;
            end

            if ((state == S_SHOW) && (state_nxt == S_ARM)) begin
                round_idx <= round_idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_round_sequencer.sv
// tb/tb_round_sequencer.sv - directed self-checking bench for round_sequencer
module tb_round_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btnS = 1'b0;
    logic [13:0] rand_num = 14'd0;
    logic [13:0] number = 14'd0;

    logic        count_en_1, count_clr_1, done_1;
    logic [1:0]  select_1;
    logic [13:0] target_1, err_1;
    logic [15:0] total_1, led_1;
    logic [3:0]  round_idx_1;

    logic        count_en_8, count_clr_8, done_8;
    logic [1:0]  select_8;
    logic [13:0] target_8, err_8;
    logic [15:0] total_8, led_8;
    logic [3:0]  round_idx_8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    round_sequencer #(.ROUNDS(1), .WIN_THRESH(500), .MAX_NUM(9999), .SHOW_TICKS(8)) dut1 (
        .clk(clk), .rst(rst), .btnS(btnS), .rand_num(rand_num), .number(number),
        .count_en(count_en_1), .count_clr(count_clr_1), .select(select_1),
        .target(target_1), .err(err_1), .total(total_1), .round_idx(round_idx_1),
        .led(led_1), .done(done_1)
    );

    round_sequencer #(.ROUNDS(8), .WIN_THRESH(500), .MAX_NUM(9999), .SHOW_TICKS(8)) dut8 (
        .clk(clk), .rst(rst), .btnS(btnS), .rand_num(rand_num), .number(number),
        .count_en(count_en_8), .count_clr(count_clr_8), .select(select_8),
        .target(target_8), .err(err_8), .total(total_8), .round_idx(round_idx_8),
        .led(led_8), .done(done_8)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press();
        btnS = 1'b1;
        tick();
        btnS = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        btnS = 1'b0;
        rst  = 1'b1;
        ticks(2);
        rst  = 1'b0;
        tick();
    endtask

    initial begin
        // Reset with the button held: everything zero, no start afterwards.
        btnS = 1'b1;
        rst  = 1'b1;
        ticks(2);
        check_eq("rst_select", select_8, 0);
        check_eq("rst_outputs", {count_en_8, count_clr_8, done_8, round_idx_8}, 0);
        check_eq("rst_scores", {target_8, err_8}, 0);
        check_eq("rst_total_led", {total_8, led_8}, 0);
        rst = 1'b0;
        ticks(3);
        check_eq("held_btn_idle", select_8, 0);
        check_eq("held_btn_noclr", count_clr_8, 0);
        btnS = 1'b0;
        tick();

        // Single round, stop at 1300 against target 1200.
        rand_num = 14'd1200;
        number   = 14'd0;
        btnS = 1'b1;
        tick();
        check_eq("arm_select", select_8, 3);
        check_eq("arm_clr", count_clr_8, 1);
        btnS = 1'b0;
        tick();
        check_eq("arm_target", target_1, 1200);
        press();
        check_eq("run_count_en", count_en_1, 1);
        check_eq("run_select", select_1, 1);
        number = 14'd1300;
        press();
        check_eq("r1_err", err_1, 100);
        check_eq("r1_led", led_1, 16'h0001);
        check_eq("r1_total", total_1, 100);
        check_eq("r1_show_select", select_1, 2);
        ticks(7);
        check_eq("r1_not_done_yet", done_1, 0);
        tick();
        check_eq("r1_done", done_1, 1);
        check_eq("r8_next_round", round_idx_8, 1);
        check_eq("r8_rearm", select_8, 3);

        // Reset in the middle of RUN discards the partial score.
        press();
        number = 14'd4000;
        tick();
        check_eq("mid_run_en", count_en_8, 1);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_select", select_8, 0);
        check_eq("mid_rst_en", count_en_8, 0);
        check_eq("mid_rst_total", total_8, 0);
        check_eq("mid_rst_led", led_8, 0);
        check_eq("mid_rst_round", round_idx_8, 0);
        rst = 1'b0;
        tick();

        // Timeout with target 50.
        number   = 14'd0;
        rand_num = 14'd50;
        press();
        check_eq("to_target", target_8, 50);
        press();
        number = 14'd9998;
        tick();
        check_eq("to_still_run", count_en_8, 1);
        number = 14'd9999;
        tick();
        check_eq("to_en_drop", count_en_8, 0);
        check_eq("to_judge_select", select_8, 2);
        tick();
        check_eq("to_err", err_8, 9949);
        check_eq("to_led", led_8, 0);
        check_eq("to_total", total_8, 9949);

        // Press and timeout together: one judge, one round step.
        do_reset();
        number   = 14'd0;
        rand_num = 14'd12000;
        press();
        check_eq("fold_target", target_8, 2001);
        press();
        number = 14'd9999;
        btnS   = 1'b1;
        tick();
        btnS   = 1'b0;
        tick();
        check_eq("dbl_err", err_8, 7998);
        check_eq("dbl_round0", round_idx_8, 0);
        press();
        ticks(6);
        check_eq("dbl_rearm", select_8, 3);
        check_eq("dbl_round1", round_idx_8, 1);
        ticks(2);
        check_eq("dbl_stays_arm", select_8, 3);
        check_eq("dbl_round_hold", round_idx_8, 1);

        // Eight timeouts against target 0 saturate the total.
        do_reset();
        number   = 14'd9999;
        rand_num = 14'd9999;
        press();
        for (int r = 0; r < 8; r++) begin
            press();
            ticks(9);
            if (r == 0) check_eq("sat_target0", target_8, 0);
            if (r == 5) check_eq("sat_total6", total_8, 59994);
        end
        check_eq("sat_total", total_8, 16'hFFFF);
        check_eq("sat_done", done_8, 1);
        check_eq("sat_led", led_8, 0);
        check_eq("sat_round", round_idx_8, 7);
        press();
        check_eq("done_to_idle", {done_8, select_8}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
